// File: rtl/n2bcd_pkg.sv
// n2bcd_pkg
// Shared constants, state encoding and a nibble helper for the
// signed-binary-to-BCD conversion scheduler and its shift-add-3 core.
// No ports (package).

package n2bcd_pkg;

    localparam logic [3:0] BCD_SIGN_NEG = 4'd5;
    localparam logic [3:0] BCD_SIGN_POS = 4'd0;
    localparam int         MAG_MAX      = 9999;
    localparam int         MAG_W        = 14;
    localparam int         DIGITS       = 4;
    localparam int         SHIFT_CYCLES = 14;
    localparam int         BCD_W        = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Double-dabble correction: a digit of 5 or more would overflow past 9
    // once doubled, so bias it by 3 before the shift.
    function automatic logic [3:0] add3_nib(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/dd_bcd_core.sv
// dd_bcd_core
// Iterative shift-add-3 (double-dabble) datapath. Pure datapath, no
// sequencing: the owner asserts load once, then step once per bit.
//
// Ports:
//   clk     system clock
//   rst     asynchronous, active-high reset
//   load    capture mag and clear the BCD accumulator
//   mag     MAG_W-bit unsigned magnitude to convert
//   step    perform one add-3-then-shift iteration
//   digits  BCD value the accumulator takes on the next step; after the
//           last step is applied this is the final result, which lets the
//           owner register it on the same edge as that step

module dd_bcd_core
    import n2bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [MAG_W-1:0] mag,
    input  logic             step,
    output logic [BCD_W-1:0] digits
);

    logic [MAG_W-1:0] mag_sr;
    logic [BCD_W-1:0] bcd_r;
    logic [BCD_W-1:0] bcd_adj;

    always_comb begin
        bcd_adj = bcd_r;
        for (int i = 0; i < DIGITS; i++) begin
            bcd_adj[4*i +: 4] = add3_nib(bcd_r[4*i +: 4]);
        end
    end

    assign digits = {bcd_adj[BCD_W-2:0], mag_sr[MAG_W-1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_sr <= '0;
            bcd_r  <= '0;
        end else if (load) begin
            mag_sr <= mag;
            bcd_r  <= '0;
        end else if (step) begin
            bcd_r  <= digits;
            mag_sr <= {mag_sr[MAG_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched
// Shares one iterative signed-binary-to-BCD converter among NREQ
// requesters. Arbitrates, clamps |value| to 9999, tracks the sign and
// sequences the dd_bcd_core datapath.
//
// Build option:
//   BCD_SCHED_RR_ARB_EN  defined   -> round-robin arbitration
//                        undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk      system clock
//   rst      asynchronous, active-high reset
//   req      per-requester level request, held until gnt
//   din      requester i's signed W-bit value at [i*W +: W]
//   gnt      one-hot, one-cycle pulse: request accepted, din captured
//   done     one-hot, one-cycle pulse to the owner: bcd_out valid
//   bcd_out  {sign nibble (5 = negative), thousands, hundreds, tens, units}
//   ovf      magnitude exceeded 9999 and was clamped; holds with bcd_out
//   busy     high while a conversion occupies SHIFT or DONE
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for any req; the capture edge grants and loads core
// SHIFT | 14 double-dabble steps, cnt counts down to terminal 0
// DONE  | one cycle with done[id] high, then back to IDLE

module bcd_conv_sched
    import n2bcd_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] din,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [BCD_W+3:0]  bcd_out,
    output logic              ovf,
    output logic              busy
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNTW = $clog2(SHIFT_CYCLES);

    state_t           state;
    logic [CNTW-1:0]  cnt;
    logic [IDXW-1:0]  id;
    logic [IDXW-1:0]  win;
    logic             sign_r;
    logic             ovf_r;

    logic [W-1:0]     din_w;
    logic [W:0]       mag_full;
    logic             mag_ovf;
    logic [MAG_W-1:0] mag_ld;
    logic             load;
    logic             step;
    logic [BCD_W-1:0] digits;

`ifdef BCD_SCHED_RR_ARB_EN
    // ptr is where the next search begins, i.e. one past the last grant.
    logic [IDXW-1:0]  ptr;

    always_comb begin
        win = '0;
        // Walk downward so the closest index at or after ptr wins last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                win = IDXW'((int'(ptr) + k) % NREQ);
            end
        end
    end
`else
    always_comb begin
        win = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                win = IDXW'(k);
            end
        end
    end
`endif

    assign din_w = din[int'(win)*W +: W];

    // One extra bit so the most negative input still has a positive magnitude.
    assign mag_full = din_w[W-1] ? -{din_w[W-1], din_w} : {din_w[W-1], din_w};
    assign mag_ovf  = mag_full > (W+1)'(MAG_MAX);
    assign mag_ld   = mag_ovf ? MAG_W'(MAG_MAX) : MAG_W'(mag_full);

    assign load = (state == IDLE) && (|req);
    assign step = (state == SHIFT);

    dd_bcd_core u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .mag    (mag_ld),
        .step   (step),
        .digits (digits)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            id      <= '0;
            sign_r  <= 1'b0;
            ovf_r   <= 1'b0;
            gnt     <= '0;
            done    <= '0;
            bcd_out <= '0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
`ifdef BCD_SCHED_RR_ARB_EN
            ptr     <= '0;
`endif
        end else begin
            gnt  <= '0;
            done <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt    <= NREQ'(1) << win;
                        id     <= win;
                        sign_r <= din_w[W-1];
                        ovf_r  <= mag_ovf;
                        cnt    <= CNTW'(SHIFT_CYCLES - 1);
                        busy   <= 1'b1;
                        state  <= SHIFT;
`ifdef BCD_SCHED_RR_ARB_EN
                        ptr    <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
`endif
                    end
                end
                SHIFT: begin
                    // The core applies its final step on this same edge,
                    // so digits already carries the finished result.
                    if (cnt == '0) begin
                        done    <= NREQ'(1) << id;
                        bcd_out <= {sign_r ? BCD_SIGN_NEG : BCD_SIGN_POS, digits};
                        ovf     <= ovf_r;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// tb_bcd_conv_sched
// Directed, self-checking bench for bcd_conv_sched (NREQ=4, W=16).
// Follows BCD_SCHED_RR_ARB_EN to pick the expected arbitration order.

module tb_bcd_conv_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] din;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [19:0] bcd_out;
    logic        ovf;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_conv_sched #(.NREQ(4), .W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .din     (din),
        .gnt     (gnt),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf),
        .busy    (busy)
    );

    // Drive one request and collect what came back; callers do the checks.
    task automatic run_conv(input int idx, input logic [15:0] val,
                            output logic [3:0] g, output logic [3:0] d,
                            output logic [19:0] b, output logic o, output int lat);
        int tg;
        g = '0; d = '0; b = '0; o = 1'b0; lat = -1; tg = -1;
        @(negedge clk);
        din[idx*16 +: 16] = val;
        req[idx] = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            if (gnt !== 4'h0 && tg < 0) begin
                g = gnt;
                tg = t;
                req[idx] = 1'b0;
            end
            if (done !== 4'h0) begin
                d = done;
                b = bcd_out;
                o = ovf;
                lat = (tg < 0) ? -1 : t - tg;
                break;
            end
        end
        req[idx] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req = '0;
        din = '0;
        repeat (3) @(negedge clk);
        checks++; if (gnt !== 4'h0) begin errors++; $display("FAIL reset_gnt: got %h expected %h", gnt, 4'h0); end
        checks++; if (done !== 4'h0) begin errors++; $display("FAIL reset_done: got %h expected %h", done, 4'h0); end
        checks++; if (bcd_out !== 20'h0) begin errors++; $display("FAIL reset_bcd: got %h expected %h", bcd_out, 20'h0); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_arbitration;
        logic [3:0]  g_v  [4];
        int          g_t  [4];
        logic [3:0]  d_v  [4];
        logic [19:0] d_b  [4];
        logic [3:0]  exp_g;
        logic [19:0] exp_b;
        int ng, nd;
        ng = 0; nd = 0;
        for (int k = 0; k < 4; k++) begin
            g_v[k] = '0; g_t[k] = -100; d_v[k] = '0; d_b[k] = '0;
        end
        @(negedge clk);
        din = {16'd4, 16'd3, 16'd2, 16'd1};
        req = 4'hF;
        for (int t = 1; t <= 100 && nd < 4; t++) begin
            @(negedge clk);
            if (gnt !== 4'h0) begin
                if (ng < 4) begin
                    g_v[ng] = gnt;
                    g_t[ng] = t;
                end
                ng++;
                req = req & ~gnt;
            end
            if (done !== 4'h0) begin
                d_v[nd] = done;
                d_b[nd] = bcd_out;
                nd++;
`ifndef BCD_SCHED_RR_ARB_EN
                req[0] = 1'b1;
`endif
                if (nd == 4) req = '0;
            end
        end
        req = '0;
        checks++; if (nd !== 4) begin errors++; $display("FAIL arb_done_count: got %0d expected 4", nd); end
        for (int k = 0; k < 4; k++) begin
`ifdef BCD_SCHED_RR_ARB_EN
            exp_g = 4'(1 << k);
            exp_b = 20'(k + 1);
`else
            exp_g = 4'b0001;
            exp_b = 20'h00001;
`endif
            checks++; if (g_v[k] !== exp_g) begin errors++; $display("FAIL arb_gnt%0d: got %h expected %h", k, g_v[k], exp_g); end
            checks++; if (d_v[k] !== exp_g) begin errors++; $display("FAIL arb_done%0d: got %h expected %h", k, d_v[k], exp_g); end
            checks++; if (d_b[k] !== exp_b) begin errors++; $display("FAIL arb_bcd%0d: got %h expected %h", k, d_b[k], exp_b); end
            if (k > 0) begin
                checks++; if (g_t[k] - g_t[k-1] !== 16) begin errors++; $display("FAIL arb_spacing%0d: got %0d expected 16", k, g_t[k] - g_t[k-1]); end
            end
        end
    endtask

    task automatic test_single;
        logic [3:0] g, d; logic [19:0] b; logic o; int lat;
        run_conv(0, 16'd1234, g, d, b, o, lat);
        checks++; if (g !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %h expected %h", g, 4'b0001); end
        checks++; if (d !== 4'b0001) begin errors++; $display("FAIL single_done: got %h expected %h", d, 4'b0001); end
        checks++; if (b !== 20'h01234) begin errors++; $display("FAIL single_bcd: got %h expected %h", b, 20'h01234); end
        checks++; if (o !== 1'b0) begin errors++; $display("FAIL single_ovf: got %b expected 0", o); end
        checks++; if (lat !== 14) begin errors++; $display("FAIL single_latency: got %0d expected 14", lat); end
    endtask

    task automatic test_negative;
        logic [3:0] g, d; logic [19:0] b; logic o; int lat;
        run_conv(2, 16'hFE05, g, d, b, o, lat);   // -507
        checks++; if (g !== 4'b0100) begin errors++; $display("FAIL neg_gnt: got %h expected %h", g, 4'b0100); end
        checks++; if (d !== 4'b0100) begin errors++; $display("FAIL neg_done: got %h expected %h", d, 4'b0100); end
        checks++; if (b !== 20'h50507) begin errors++; $display("FAIL neg_bcd: got %h expected %h", b, 20'h50507); end
        checks++; if (o !== 1'b0) begin errors++; $display("FAIL neg_ovf: got %b expected 0", o); end
        checks++; if (lat !== 14) begin errors++; $display("FAIL neg_latency: got %0d expected 14", lat); end
    endtask

    task automatic test_boundaries;
        logic [15:0] vals [7];
        logic [19:0] ebcd [7];
        logic        eovf [7];
        logic [3:0] g, d, eoh; logic [19:0] b; logic o; int lat;
        // 9999, 10000, 32767, 0, -1, -9999, -32768
        vals = '{16'd9999, 16'd10000, 16'd32767, 16'd0, 16'hFFFF, 16'hD8F1, 16'h8000};
        ebcd = '{20'h09999, 20'h09999, 20'h09999, 20'h00000, 20'h50001, 20'h59999, 20'h59999};
        eovf = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 7; k++) begin
            eoh = 4'(1 << (k % 4));
            run_conv(k % 4, vals[k], g, d, b, o, lat);
            checks++; if (d !== eoh) begin errors++; $display("FAIL bound%0d_done: got %h expected %h", k, d, eoh); end
            checks++; if (b !== ebcd[k]) begin errors++; $display("FAIL bound%0d_bcd: got %h expected %h", k, b, ebcd[k]); end
            checks++; if (o !== eovf[k]) begin errors++; $display("FAIL bound%0d_ovf: got %b expected %b", k, o, eovf[k]); end
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] g, d; logic [19:0] b; logic o; int lat;
        int tg, seen;
        tg = -1; seen = 0;
        @(negedge clk);
        din[16 +: 16] = 16'd999;
        req[1] = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            if (gnt !== 4'h0) begin tg = t; break; end
        end
        req[1] = 1'b0;
        checks++; if (tg < 0) begin errors++; $display("FAIL rstmid_gnt: got none expected grant within 20 cycles"); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_pre: got %b expected 1", busy); end
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (gnt !== 4'h0) begin errors++; $display("FAIL rstmid_gnt0: got %h expected %h", gnt, 4'h0); end
        checks++; if (done !== 4'h0) begin errors++; $display("FAIL rstmid_done0: got %h expected %h", done, 4'h0); end
        checks++; if (bcd_out !== 20'h0) begin errors++; $display("FAIL rstmid_bcd0: got %h expected %h", bcd_out, 20'h0); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rstmid_ovf0: got %b expected 0", ovf); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy0: got %b expected 0", busy); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (done !== 4'h0 || gnt !== 4'h0) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", seen); end
        run_conv(1, 16'd42, g, d, b, o, lat);
        checks++; if (d !== 4'b0010) begin errors++; $display("FAIL rstmid_after_done: got %h expected %h", d, 4'b0010); end
        checks++; if (b !== 20'h00042) begin errors++; $display("FAIL rstmid_after_bcd: got %h expected %h", b, 20'h00042); end
        checks++; if (lat !== 14) begin errors++; $display("FAIL rstmid_after_latency: got %0d expected 14", lat); end
    endtask

    task automatic test_late_req;
        logic [3:0] g0, g1, d0, d1; logic [19:0] b0, b1;
        int tg0, tg1, td0, td1;
        g0 = '0; g1 = '0; d0 = '0; d1 = '0; b0 = '0; b1 = '0;
        tg0 = -1; tg1 = -1; td0 = -1; td1 = -1;
        @(negedge clk);
        din[0 +: 16] = 16'd7;
        req[0] = 1'b1;
        for (int t = 1; t <= 60; t++) begin
            @(negedge clk);
            if (gnt !== 4'h0) begin
                if (tg0 < 0) begin g0 = gnt; tg0 = t; req[0] = 1'b0; end
                else begin g1 = gnt; tg1 = t; req[1] = 1'b0; end
            end
            if (tg0 >= 0 && t == tg0 + 3) begin
                din[16 +: 16] = 16'd88;
                req[1] = 1'b1;
            end
            if (done !== 4'h0) begin
                if (td0 < 0) begin d0 = done; b0 = bcd_out; td0 = t; end
                else begin d1 = done; b1 = bcd_out; td1 = t; break; end
            end
        end
        req = '0;
        checks++; if (g0 !== 4'b0001) begin errors++; $display("FAIL late_gnt0: got %h expected %h", g0, 4'b0001); end
        checks++; if (d0 !== 4'b0001) begin errors++; $display("FAIL late_done0: got %h expected %h", d0, 4'b0001); end
        checks++; if (b0 !== 20'h00007) begin errors++; $display("FAIL late_bcd0: got %h expected %h", b0, 20'h00007); end
        checks++; if (g1 !== 4'b0010) begin errors++; $display("FAIL late_gnt1: got %h expected %h", g1, 4'b0010); end
        checks++; if (tg1 - td0 !== 2) begin errors++; $display("FAIL late_gap: got %0d expected 2", tg1 - td0); end
        checks++; if (d1 !== 4'b0010) begin errors++; $display("FAIL late_done1: got %h expected %h", d1, 4'b0010); end
        checks++; if (b1 !== 20'h00088) begin errors++; $display("FAIL late_bcd1: got %h expected %h", b1, 20'h00088); end
        checks++; if (td1 - tg1 !== 14) begin errors++; $display("FAIL late_latency1: got %0d expected 14", td1 - tg1); end
    endtask

    initial begin
        test_reset;
        test_arbitration;
        test_single;
        test_negative;
        test_boundaries;
        test_reset_mid;
        test_late_req;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
